gru_sequence_scheduler: RTL and testbench
=========================================

// Module: gru_sequence_scheduler
// PURPOSE
//  Runs one GRU cell over an input sequence of seq_len timesteps, one step at a time.
//  Per step: fetches x_t over a valid/ready stream, pulses cell start, waits for cell done.
//  Then feeds h_t back as h_t_prev and emits each h_t on a valid/ready output stream.
//  Sits between the input sample buffer and the GRU cell; owns the recurrent hidden-state register.
// PARAMETERS
//  D           4   input vector length
//  H           2   hidden vector length
//  DATA_WIDTH  15  signed fixed-point word width
//  FRAC_BITS   9   fractional bits (pass-through only, no arithmetic here)
//  MAX_T       16  max sequence length; T_W = $clog2(MAX_T+1)
//  TIMEOUT     255 max cycles from cell_start to cell_done before error
// PORTS
//  clk           in   1           clock
//  rst           in   1           synchronous, active-high reset
//  seq_start     in   1           start request; accepted only in IDLE
//  seq_len       in   T_W         timesteps; sampled on accepted seq_start
//  init_zero     in   1           1: h0=0, 0: h0=h_init; sampled with seq_start
//  h_init        in   H*DW        initial hidden state
//  abort         in   1           cancel sequence
//  x_valid       in   1           x stream valid
//  x_ready       out  1           x stream ready
//  x_data        in   D*DW        x_t vector
//  cell_start    out  1           1-cycle pulse to GRU cell
//  cell_x_t      out  D*DW        x_t to cell; held stable while cell runs
//  cell_h_prev   out  H*DW        h_t_prev to cell; held stable while cell runs
//  cell_done     in   1           1-cycle done pulse from cell
//  cell_h_t      in   H*DW        cell result; valid with cell_done
//  h_out_valid   out  1           output valid
//  h_out_ready   in   1           output ready
//  h_out         out  H*DW        h_t of current step
//  h_out_last    out  1           marks final step; qualified by h_out_valid
//  t_idx         out  T_W         current step index
//  busy          out  1           state != IDLE
//  seq_done      out  1           1-cycle pulse at sequence end
//  err_len       out  1           1-cycle pulse: seq_len > MAX_T, request dropped
//  err_timeout   out  1           sticky; cleared by rst or accepted seq_start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; h_reg, x_reg, t_idx, timeout counter = 0.
//  FSM: IDLE -> FETCH_X -> START -> WAIT_CELL -> EMIT -> (FETCH_X | DONE); DONE -> IDLE; ERR -> IDLE.
//  IDLE, seq_start:
//   - seq_len==0: pulse seq_done next cycle; no cell activity.
//   - seq_len>MAX_T: pulse err_len; stay IDLE.
//   - otherwise: t_idx=0; h_reg=init_zero?0:h_init; clear err_timeout; go FETCH_X.
//  seq_start while busy is ignored.
//  FETCH_X: x_ready=1 in this state only. On x_valid: x_reg<=x_data; go START.
//  START: cell_start=1 for exactly 1 cycle; timeout counter cleared; go WAIT_CELL.
//  WAIT_CELL: counter increments each cycle.
//   - On cell_done: h_reg<=cell_h_t; go EMIT.
//   - Counter reaching TIMEOUT without cell_done: set err_timeout; go ERR.
//   - ERR lasts 1 cycle and pulses seq_done; then IDLE.
//  cell_x_t=x_reg and cell_h_prev=h_reg are registered and change only in FETCH_X / WAIT_CELL updates.
//  EMIT: h_out_valid=1, h_out=h_reg, h_out_last=(t_idx==len-1).
//   - Hold all three stable until h_out_ready.
//   - On handshake: if last go DONE, else t_idx++ and go FETCH_X.
//  DONE: seq_done=1 for 1 cycle; h_reg retained for readback via cell_h_prev.
//  Latency: x accept -> cell_start 1 cycle; cell_done -> h_out_valid 1 cycle.
//   - Step overhead excluding cell = 3 cycles with ready/valid held high.
//  abort (any non-IDLE state, priority over all else): next state IDLE; all handshake outputs drop.
//   - No seq_done pulse; a later stray cell_done in IDLE is ignored.
//  rst mid-operation: identical to reset; stray cell_done after rst is ignored.
//  Simultaneous cell_done and timeout expiry on the same cycle: cell_done wins.
// STRUCTURE
//  gru_pkg: seq_state_t enum (IDLE, FETCH_X, START, WAIT_CELL, EMIT, DONE, ERR), T_W function.
//  Sub-module gru_watchdog_counter (clear, enable, expired) for the TIMEOUT count.
// TESTING
//  1. len=3, init_zero=1, x always valid, cell done after 5 cycles (stub h_t=h_prev+1 LSB):
//     -> h_out = 1, 2, 3 LSB; last on 3rd; one seq_done.
//  2. len=2, h_init={0x0200,0x7E00}, init_zero=0:
//     -> first cell_h_prev equals h_init; second equals first cell_h_t.
//  3. h_out_ready low for 10 cycles in EMIT -> h_out stable; no new x_ready/cell_start until handshake.
//  4. Cell never responds, TIMEOUT=8 -> err_timeout at cycle 8 after start; seq_done pulse; IDLE.
//     Next seq_start clears err_timeout.
//  5. seq_len=0 -> seq_done only.
//     seq_len=MAX_T+1 -> err_len only; busy stays 0.
//  6. abort in WAIT_CELL, then cell_done 2 cycles later -> IDLE; h_reg unchanged; no h_out_valid.
//     rst mid-EMIT -> all outputs 0.

Source files
------------

// File: rtl/gru_sequence_scheduler_pkg.sv
// ============================================================================
// Module      : gru_sequence_scheduler_pkg
// Description : Shared state encoding and width helper for the GRU sequence
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gru_sequence_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_X   = 3'd1,
        START     = 3'd2,
        WAIT_CELL = 3'd3,
        EMIT      = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6
    } seq_state_t;

    // Width needed to hold step counts 0..max_t inclusive.
    function automatic int t_width(input int max_t);
        return $clog2(max_t + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gru_sequence_scheduler_if.sv
// ============================================================================
// Module      : gru_sequence_scheduler_if
// Description : x input stream, GRU cell handshake and h output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gru_sequence_scheduler_if #(
    parameter int D          = 4,
    parameter int H          = 2,
    parameter int DATA_WIDTH = 15
);

    logic                    x_valid;
    logic                    x_ready;
    logic [D*DATA_WIDTH-1:0] x_data;

    logic                    cell_start;
    logic [D*DATA_WIDTH-1:0] cell_x_t;
    logic [H*DATA_WIDTH-1:0] cell_h_prev;
    logic                    cell_done;
    logic [H*DATA_WIDTH-1:0] cell_h_t;

    logic                    h_out_valid;
    logic                    h_out_ready;
    logic [H*DATA_WIDTH-1:0] h_out;
    logic                    h_out_last;

    // Scheduler side
    modport master (
        input  x_valid, x_data, cell_done, cell_h_t, h_out_ready,
        output x_ready, cell_start, cell_x_t, cell_h_prev,
               h_out_valid, h_out, h_out_last
    );

    // Sample buffer / GRU cell / consumer side
    modport slave (
        output x_valid, x_data, cell_done, cell_h_t, h_out_ready,
        input  x_ready, cell_start, cell_x_t, cell_h_prev,
               h_out_valid, h_out, h_out_last
    );

endinterface

`default_nettype wire

// File: rtl/gru_sequence_scheduler_watchdog.sv
// ============================================================================
// Module      : gru_sequence_scheduler_watchdog
// Description : Saturating cycle counter that flags the cycle in which the
//               count reaches TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gru_sequence_scheduler_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam int              c_CW      = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_LIMIT   = c_CW'(TIMEOUT);
    localparam logic [c_CW-1:0] c_LAST_OK = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    // Flags the enabled cycle whose increment brings the count to TIMEOUT.
    assign o_expired = i_enable && (r_count == c_LAST_OK);

endmodule

`default_nettype wire

// File: rtl/gru_sequence_scheduler.sv
// ============================================================================
// Module      : gru_sequence_scheduler
// Description : Steps one GRU cell over a sequence, owning the recurrent h.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gru_sequence_scheduler
    import gru_sequence_scheduler_pkg::*;
#(
    parameter int D          = 4,
    parameter int H          = 2,
    parameter int DATA_WIDTH = 15,
    parameter int FRAC_BITS  = 9,
    parameter int MAX_T      = 16,
    parameter int TIMEOUT    = 255,
    parameter int T_W        = t_width(MAX_T)
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    seq_start,
    input  wire logic [T_W-1:0]          seq_len,
    input  wire logic                    init_zero,
    input  wire logic [H*DATA_WIDTH-1:0] h_init,
    input  wire logic                    abort,
    gru_sequence_scheduler_if.master     bus,
    output logic [T_W-1:0]               t_idx,
    output logic                         busy,
    output logic                         seq_done,
    output logic                         err_len,
    output logic                         err_timeout
);

    if ((FRAC_BITS < 0) || (FRAC_BITS >= DATA_WIDTH) || (MAX_T < 1) || (TIMEOUT < 1)) begin : g_param_check
        $error("gru_sequence_scheduler: illegal parameter combination");
    end

    seq_state_t              r_state;
    seq_state_t              w_state_nxt;

    logic [H*DATA_WIDTH-1:0] r_h;
    logic [D*DATA_WIDTH-1:0] r_x;
    logic [T_W-1:0]          r_t_idx;
    logic [T_W-1:0]          r_len;
    logic                    r_err_timeout;
    logic                    r_err_len;
    logic                    r_zero_done;

    logic                    w_len_zero;
    logic                    w_len_big;
    logic                    w_idle_req;
    logic                    w_last;
    logic                    w_start_ok;
    logic                    w_x_take;
    logic                    w_h_load;
    logic                    w_t_inc;
    logic                    w_timeout_hit;
    logic                    w_wd_clear;
    logic                    w_wd_enable;
    logic                    w_wd_expired;

    assign w_len_zero = (seq_len == '0);
    assign w_len_big  = (int'(seq_len) > MAX_T);
    assign w_idle_req = seq_start && (r_state == IDLE);
    assign w_last     = (r_t_idx == (r_len - T_W'(1)));

    assign w_wd_clear  = (r_state == START);
    assign w_wd_enable = (r_state == WAIT_CELL);

    gru_sequence_scheduler_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_start_ok      = 1'b0;
        w_x_take        = 1'b0;
        w_h_load        = 1'b0;
        w_t_inc         = 1'b0;
        w_timeout_hit   = 1'b0;
        bus.x_ready     = 1'b0;
        bus.cell_start  = 1'b0;
        bus.h_out_valid = 1'b0;
        bus.h_out_last  = 1'b0;
        busy            = (r_state != IDLE);
        seq_done        = r_zero_done;

        case (r_state)
            IDLE: begin
                if (w_idle_req && !w_len_zero && !w_len_big) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = FETCH_X;
                end
            end
            FETCH_X: begin
                bus.x_ready = 1'b1;
                if (bus.x_valid) begin
                    w_x_take    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                bus.cell_start = 1'b1;
                w_state_nxt    = WAIT_CELL;
            end
            WAIT_CELL: begin
                // A done arriving on the expiry cycle still counts as success.
                if (bus.cell_done) begin
                    w_h_load    = 1'b1;
                    w_state_nxt = EMIT;
                end else if (w_wd_expired) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = ERR;
                end
            end
            EMIT: begin
                bus.h_out_valid = 1'b1;
                bus.h_out_last  = w_last;
                if (bus.h_out_ready) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_t_inc     = 1'b1;
                        w_state_nxt = FETCH_X;
                    end
                end
            end
            DONE: begin
                seq_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            ERR: begin
                seq_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort suppresses every datapath update along with the transition.
        if (abort && (r_state != IDLE)) begin
            w_state_nxt   = IDLE;
            w_x_take      = 1'b0;
            w_h_load      = 1'b0;
            w_t_inc       = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h           <= '0;
            r_x           <= '0;
            r_t_idx       <= '0;
            r_len         <= '0;
            r_err_timeout <= 1'b0;
            r_err_len     <= 1'b0;
            r_zero_done   <= 1'b0;
        end else begin
            r_err_len   <= w_idle_req && w_len_big;
            r_zero_done <= w_idle_req && w_len_zero;
            if (w_start_ok) begin
                r_t_idx       <= '0;
                r_len         <= seq_len;
                r_h           <= init_zero ? '0 : h_init;
                r_err_timeout <= 1'b0;
            end
            if (w_x_take) begin
                r_x <= bus.x_data;
            end
            if (w_h_load) begin
                r_h <= bus.cell_h_t;
            end
            if (w_t_inc) begin
                r_t_idx <= r_t_idx + T_W'(1);
            end
            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign bus.cell_x_t    = r_x;
    assign bus.cell_h_prev = r_h;
    assign bus.h_out       = r_h;
    assign t_idx           = r_t_idx;
    assign err_len         = r_err_len;
    assign err_timeout     = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_gru_sequence_scheduler.sv
// ============================================================================
// Module      : tb_gru_sequence_scheduler
// Description : Directed bench with a GRU cell stub (h_t = h_prev + 1 LSB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gru_sequence_scheduler;

    localparam int c_D   = 4;
    localparam int c_H   = 2;
    localparam int c_DW  = 15;
    localparam int c_TW  = 5;

    localparam logic [59:0] c_X1   = 60'h123456789ABCDEF;
    localparam logic [59:0] c_X2   = 60'hFEDCBA987654321;
    localparam logic [29:0] c_HI2  = {15'h0200, 15'h7E00};
    localparam logic [29:0] c_HI6  = {15'h0155, 15'h2AAA};

    logic             clk;
    logic             rst;
    logic             seq_start;
    logic [c_TW-1:0]  seq_len;
    logic             init_zero;
    logic [29:0]      h_init;
    logic             abort;
    logic [c_TW-1:0]  t_idx;
    logic             busy;
    logic             seq_done;
    logic             err_len;
    logic             err_timeout;

    gru_sequence_scheduler_if #(.D(c_D), .H(c_H), .DATA_WIDTH(c_DW)) bus ();

    gru_sequence_scheduler #(
        .D          (c_D),
        .H          (c_H),
        .DATA_WIDTH (c_DW),
        .FRAC_BITS  (9),
        .MAX_T      (16),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seq_start   (seq_start),
        .seq_len     (seq_len),
        .init_zero   (init_zero),
        .h_init      (h_init),
        .abort       (abort),
        .bus         (bus),
        .t_idx       (t_idx),
        .busy        (busy),
        .seq_done    (seq_done),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_seq_done = 0;

    bit          stub_en;
    int          stub_delay;
    logic        stub_done;
    logic [29:0] stub_h;
    logic        stray_done;
    logic [29:0] stray_h;

    assign bus.cell_done = stub_done | stray_done;
    assign bus.cell_h_t  = stray_done ? stray_h : stub_h;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] lanes(input logic [14:0] hi, input logic [14:0] lo);
        return {hi, lo};
    endfunction

    // Cell stub: done arrives stub_delay cycles after the cell_start cycle.
    initial begin
        stub_done = 1'b0;
        stub_h    = '0;
        forever begin
            @(negedge clk);
            if (stub_en && bus.cell_start) begin
                repeat (stub_delay) @(negedge clk);
                stub_h    = {bus.cell_h_prev[29:15] + 15'd1, bus.cell_h_prev[14:0] + 15'd1};
                stub_done = 1'b1;
                @(negedge clk);
                stub_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (seq_done === 1'b1) n_seq_done++;
    end

    task automatic start_seq(input logic [c_TW-1:0] len, input bit iz, input logic [29:0] hi);
        seq_len   = len;
        init_zero = iz;
        h_init    = hi;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
    endtask

    task automatic wait_cs(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.cell_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_cs_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_hv(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.h_out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_hv_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_idle_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int done0;
        int hold_bad;
        int cyc;
        int quiet_bad;

        rst             = 1'b1;
        seq_start       = 1'b0;
        seq_len         = '0;
        init_zero       = 1'b0;
        h_init          = '0;
        abort           = 1'b0;
        bus.x_valid     = 1'b0;
        bus.x_data      = '0;
        bus.h_out_ready = 1'b0;
        stub_en         = 1'b0;
        stub_delay      = 5;
        stray_done      = 1'b0;
        stray_h         = '0;

        repeat (3) @(negedge clk);
        chk("rst_ctl", {busy, seq_done, err_len, err_timeout, bus.x_ready,
                        bus.cell_start, bus.h_out_valid, bus.h_out_last}, 64'd0);
        chk("rst_hout", bus.h_out, 64'd0);
        chk("rst_tidx", t_idx, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // len=3 from h0=0: h_out walks 1,2,3 LSB per lane, last on the third
        stub_en         = 1'b1;
        stub_delay      = 5;
        bus.x_valid     = 1'b1;
        bus.x_data      = c_X1;
        bus.h_out_ready = 1'b1;
        done0           = n_seq_done;
        start_seq(5'd3, 1'b1, '0);
        for (int s = 0; s < 3; s++) begin
            wait_hv("t1");
            chk("t1_hout", bus.h_out, 64'(lanes(15'(s + 1), 15'(s + 1))));
            chk("t1_last", bus.h_out_last, 64'(s == 2));
            chk("t1_tidx", t_idx, 64'(s));
            @(negedge clk);
        end
        wait_idle("t1");
        chk("t1_ndone", 64'(n_seq_done - done0), 64'd1);

        // h_init seeds the first step; the second step sees the first result
        start_seq(5'd2, 1'b0, c_HI2);
        wait_cs("t2a");
        chk("t2_hprev0", bus.cell_h_prev, 64'(c_HI2));
        chk("t2_x0", bus.cell_x_t, 64'(c_X1));
        bus.x_data = c_X2;
        wait_hv("t2a");
        chk("t2_hout0", bus.h_out, 64'(lanes(15'h0201, 15'h7E01)));
        @(negedge clk);
        wait_cs("t2b");
        chk("t2_hprev1", bus.cell_h_prev, 64'(lanes(15'h0201, 15'h7E01)));
        chk("t2_x1", bus.cell_x_t, 64'(c_X2));
        wait_hv("t2b");
        chk("t2_hout1", bus.h_out, 64'(lanes(15'h0202, 15'h7E02)));
        chk("t2_last1", bus.h_out_last, 64'd1);
        @(negedge clk);
        wait_idle("t2");

        // Back-pressure: EMIT holds; a seq_start while busy is ignored
        bus.h_out_ready = 1'b0;
        start_seq(5'd1, 1'b1, '0);
        wait_hv("t3");
        hold_bad  = 0;
        seq_start = 1'b1;
        seq_len   = 5'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.h_out !== lanes(15'd1, 15'd1) || bus.h_out_valid !== 1'b1 ||
                bus.h_out_last !== 1'b1 || bus.x_ready !== 1'b0 || bus.cell_start !== 1'b0)
                hold_bad++;
        end
        seq_start = 1'b0;
        chk("t3_hold", 64'(hold_bad), 64'd0);
        bus.h_out_ready = 1'b1;
        @(negedge clk);
        chk("t3_done", seq_done, 64'd1);
        chk("t3_vdrop", bus.h_out_valid, 64'd0);
        @(negedge clk);
        chk("t3_idle", busy, 64'd0);

        // Silent cell: 8 waiting cycles, error seen 9 cycles after cell_start
        stub_en = 1'b0;
        start_seq(5'd2, 1'b1, '0);
        wait_cs("t4");
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                cyc = i;
                break;
            end
        end
        chk("t4_cycles", 64'(cyc), 64'd9);
        chk("t4_seqdone", seq_done, 64'd1);
        @(negedge clk);
        chk("t4_idle", busy, 64'd0);
        chk("t4_sticky", err_timeout, 64'd1);

        // Restart clears the error; done on the expiry cycle beats the timeout
        stub_en    = 1'b1;
        stub_delay = 8;
        start_seq(5'd1, 1'b1, '0);
        chk("t4_clear", err_timeout, 64'd0);
        wait_hv("t4b");
        chk("t4b_hout", bus.h_out, 64'(lanes(15'd1, 15'd1)));
        chk("t4b_noerr", err_timeout, 64'd0);
        @(negedge clk);
        wait_idle("t4b");
        stub_delay = 5;

        // Zero length and over-length requests
        start_seq(5'd0, 1'b1, '0);
        chk("t5_zdone", {seq_done, err_len, busy}, 64'b100);
        @(negedge clk);
        chk("t5_zafter", {seq_done, busy, bus.x_ready}, 64'd0);
        start_seq(5'd17, 1'b1, '0);
        chk("t5_errlen", {err_len, seq_done, busy}, 64'b100);
        @(negedge clk);
        chk("t5_lafter", {err_len, busy}, 64'd0);

        // Abort in WAIT_CELL, stray done two cycles later is ignored
        stub_en = 1'b0;
        done0   = n_seq_done;
        start_seq(5'd16, 1'b0, c_HI6);
        chk("t6_len16", busy, 64'd1);
        wait_cs("t6");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_abort", {busy, bus.x_ready, bus.cell_start, bus.h_out_valid}, 64'd0);
        @(negedge clk);
        stray_h    = lanes(15'h1234, 15'h0ABC);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        chk("t6_hreg", bus.cell_h_prev, 64'(c_HI6));
        quiet_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.h_out_valid !== 1'b0 || busy !== 1'b0) quiet_bad++;
            @(negedge clk);
        end
        chk("t6_quiet", 64'(quiet_bad), 64'd0);
        chk("t6_nodone", 64'(n_seq_done - done0), 64'd0);

        // Reset while EMIT is stalled
        stub_en         = 1'b1;
        bus.h_out_ready = 1'b0;
        start_seq(5'd1, 1'b0, c_HI6);
        wait_hv("t7");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t7_ctl", {busy, seq_done, err_len, err_timeout, bus.x_ready,
                       bus.cell_start, bus.h_out_valid, bus.h_out_last}, 64'd0);
        chk("t7_data", {bus.h_out, bus.cell_h_prev, 4'(t_idx)}, 64'd0);
        chk("t7_xreg", bus.cell_x_t, 64'd0);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        chk("t7_stray", {busy, bus.h_out_valid, bus.h_out}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
